alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle 16-bit multiplier controller that sequences the Hack ALU through a shift-and-add loop. It sits beside the CPU datapath and owns one private `alu` instance. Every accumulation is driven through that ALU with control `{zx,nx,zy,ny,f,no} = 6'b000010` (x+y), so the ALU is the block's only adder. It returns the low 16 bits of a×b; these bits are identical for signed and unsigned operands. Status flags zr/ng are registered from the final product.

## Interface
- `EARLY_EXIT`, default 1. Value 1: stop once the remaining multiplier bits are all zero. Value 0: always perform 16 steps.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  16  multiplicand; captured when start is accepted.
- `b`  in  16  multiplier; captured when start is accepted.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse; high only in DONE.
- `product`  out  16  low 16 bits of a×b; valid from DONE until the next accepted start.
- `zr`  out  1  product == 0; registered.
- `ng`  out  1  product[15]; registered.

## Operation
- Internal registers:
  - acc[15:0], the accumulator.
  - m[15:0], the shifted multiplicand.
  - q[15:0], the shifted multiplier.
  - cnt[3:0], the step counter.
  - state, one of IDLE / CALC / DONE.
- ALU wiring:
  - x = acc, y = m, control fixed at 000010.
  - ALU zr/ng outputs are not used; zr/ng are derived from acc on the DONE transition.
- IDLE:
  - On start=1: acc←0, m←a, q←b, cnt←0, state→CALC.
  - Otherwise hold; product, zr and ng keep their last values.
- CALC, one step per cycle:
  - acc←ALU out if q[0]=1, else acc is unchanged.
  - m←{m[14:0],1'b0}; q←{1'b0,q[15:1]}; cnt←cnt+1.
- CALC exit, evaluated on the current step:
  - EARLY_EXIT=1: go to DONE when q[15:1]==0 or cnt==15.
  - EARLY_EXIT=0: go to DONE only when cnt==15.
- Entering DONE:
  - product←final acc (including the current step's update).
  - zr←(final acc==0); ng←final acc[15].
- DONE: done=1 for one cycle, then state→IDLE unconditionally.
- Arithmetic:
  - Every add is modulo 2^16; carries out of bit 15 are discarded and no overflow is flagged.
  - Bits of m shifted past bit 15 are lost.
- start while busy (CALC or DONE) is ignored; no queueing and no error.
- a and b may change freely after the accepting edge; only the captured copies are used.
- Reset:
  - rst=1 at any edge, including mid-CALC: state→IDLE.
  - acc, m, q, cnt, product ← 0; zr←1, ng←0.
  - The in-flight result is discarded and no done pulse is produced.
  - rst takes priority over start in the same cycle.

## Timing
- Reset values: busy=0, done=0, product=0x0000, zr=1, ng=0.
- Step count n:
  - EARLY_EXIT=0: n = 16.
  - EARLY_EXIT=1, b≠0: n = (index of MSB set in b)+1.
  - EARLY_EXIT=1, b=0: n = 1.
- Cycle numbering: the cycle in which start=1 is sampled in IDLE is cycle 0.
  - busy=1 in cycles 1..n+1.
  - done=1 in cycle n+1 only.
  - product/zr/ng valid from cycle n+1.
- Throughput: the earliest next accepted start is in cycle n+2, i.e. one idle cycle after done.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then a=3, b=5 with start pulsed: n=3; done in cycle 4; product=0x000F, zr=0, ng=0; busy high in cycles 1–4 only.
- a=0x1234, b=0x0000: n=1; done in cycle 2; product=0x0000, zr=1, ng=0.
- a=0xFFFF, b=0x0002: product=0xFFFE, ng=1, zr=0. Then a=0x1234, b=0x4321: n=15, product=0xF4B4, ng=1.
- EARLY_EXIT=0 instance, a=3, b=5: done exactly in cycle 17; product=0x000F.
- Start mid-CALC with different a/b: ignored, original result is returned. Second start in the done cycle: ignored. Start the following cycle: accepted.
- rst asserted in cycle 2 of a 15-step op: next cycle busy=0, product=0, zr=1, no done pulse. A subsequent 3×5 completes correctly.

Source files
------------

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Purpose
//   Multi-cycle 16-bit shift-and-add multiplier controller. A private Hack
//   ALU performs every accumulation. Its control is tied to x+y, so that ALU
//   is the block's only adder. The result is the low 16 bits of a*b, which
//   are the same for signed and unsigned operands. zr/ng are registered
//   from the final product.
//
// Parameters
//   EARLY_EXIT  1: finish as soon as the remaining multiplier bits are zero
//               0: always perform 16 steps
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous, active-high reset
//   start    in   1   operation request, sampled only while idle
//   a        in  16   multiplicand, captured on an accepted start
//   b        in  16   multiplier, captured on an accepted start
//   busy     out  1   high while calculating and in the done cycle
//   done     out  1   one-cycle completion pulse
//   product  out 16   low 16 bits of a*b, held until the next accepted start
//   zr       out  1   product == 0 (registered)
//   ng       out  1   product[15]  (registered)
//
// Also contains module alu, the Hack ALU used as the accumulator adder.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu : Hack ALU
//   x, y            in  16  operands
//   zx,nx,zy,ny,f,no in  1  Hack control bits
//   out             out 16  result
//   zr, ng          out  1  out == 0, out[15]
// ---------------------------------------------------------------------------
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        // Modulo-2^16 add: the carry out of bit 15 is dropped.
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

// ---------------------------------------------------------------------------
// alu_mul_seq : top
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] q;
    logic [3:0]        cnt;

    logic [DATA_W-1:0] alu_out;
    logic              alu_zr_unused;
    logic              alu_ng_unused;

    logic [DATA_W-1:0] acc_nxt;
    logic              last_step;

    // Accumulator adder: x = acc, y = m, control {zx,nx,zy,ny,f,no} = 000010.
    // The ALU flags are not used; zr/ng come from acc when the result
    // is committed.
    alu u_alu (
        .x   (acc),
        .y   (m),
        .zx  (1'b0),
        .nx  (1'b0),
        .zy  (1'b0),
        .ny  (1'b0),
        .f   (1'b1),
        .no  (1'b0),
        .out (alu_out),
        .zr  (alu_zr_unused),
        .ng  (alu_ng_unused)
    );

    // One shift-and-add step: add the shifted multiplicand only when the
    // current multiplier bit is set.
    always_comb begin
        acc_nxt = q[0] ? alu_out : acc;
        if (EARLY_EXIT) begin
            // q[15:1] is what remains after this step's shift. Once it is
            // zero, later steps could not change acc.
            last_step = (q[DATA_W-1:1] == '0) || (cnt == 4'd15);
        end else begin
            last_step = (cnt == 4'd15);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers. Reset clears everything, so an
    // interrupted operation leaves no trace in product/zr/ng.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        m   <= a;
                        q   <= b;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    // Bits shifted out of m past bit 15 are lost.
                    m   <= {m[DATA_W-2:0], 1'b0};
                    q   <= {1'b0, q[DATA_W-1:1]};
                    cnt <= cnt + 4'd1;
                    // The result is committed on the step that exits CALC,
                    // including that step's own accumulation.
                    if (last_step) begin
                        product <= acc_nxt;
                        zr      <= (acc_nxt == '0);
                        ng      <= acc_nxt[DATA_W-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status decoded from the state register only; starts that arrive
    // while busy are ignored.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
